// File: rtl/multi_cycle_controller.sv
// rtl/multi_cycle_controller.sv - Moore FSM sequencing the multi-cycle RV32I datapath
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   op, funct3      opcode and funct3 fields of the IR
//   zero, lt        ALU flags used to resolve conditional branches
//   pcWrite         PC load enable
//   adrSrc          memory address select (0 PC, 1 aluOut)
//   memWrite        memory write enable
//   irWrite         IR/oldPC load enable
//   regWrite        register file write enable
//   resultSrc       result mux (00 aluOut, 01 data, 10 aluResult, 11 immExt)
//   aluSrcA         ALU A mux (00 PC, 01 oldPC, 10 rs1)
//   aluSrcB         ALU B mux (00 rs2, 01 immExt, 10 const 4)
//   aluOp           ALU decoder class (00 add, 01 sub/compare, 10 funct)
//   immSrc          immediate format (000 I, 001 S, 010 J, 011 B, 100 U)
//   halted          sticky flag, set once the FSM enters HALT
//   instrCount      retired instruction count, wraps modulo 2^CNT_W

module multi_cycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             lt,
    output logic             pcWrite,
    output logic             adrSrc,
    output logic             memWrite,
    output logic             irWrite,
    output logic             regWrite,
    output logic [1:0]       resultSrc,
    output logic [1:0]       aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       aluOp,
    output logic [2:0]       immSrc,
    output logic             halted,
    output logic [CNT_W-1:0] instrCount
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALRPC,
        S_LUI,
        S_HALT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             halted_q;
    logic [CNT_W-1:0] count_q;

    // Raw enables before the reset gate.
    logic pc_we;
    logic mem_we;
    logic ir_we;
    logic reg_we;
    logic branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state <= state_next;
            // FETCH is only reached from the last state of an instruction,
            // so every entry marks one retired instruction.
            if (state_next == S_FETCH) begin
                count_q <= count_q + CNT_W'(1);
            end
            // Registered on entry so halted is already 1 during the HALT cycle.
            if (state_next == S_HALT) begin
                halted_q <= 1'b1;
            end
        end
    end

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = ~zero;
            3'b100:  branch_taken = lt;
            3'b101:  branch_taken = ~lt;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        pc_we      = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        adrSrc     = 1'b0;
        resultSrc  = 2'b00;
        aluSrcA    = 2'b00;
        aluSrcB    = 2'b00;
        aluOp      = 2'b00;
        immSrc     = 3'b000;

        case (state)
            S_FETCH: begin
                ir_we      = 1'b1;
                pc_we      = 1'b1;
                aluSrcB    = 2'b10;
                resultSrc  = 2'b10;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch/jal target into aluOut.
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
                if (op == OP_BRANCH) begin
                    immSrc = 3'b011;
                end else if (op == OP_JAL) begin
                    immSrc = 3'b010;
                end
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    default:           state_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                if (op == OP_LOAD) begin
                    state_next = S_MEMREAD;
                end else begin
                    immSrc     = 3'b001;
                    state_next = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                adrSrc     = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                resultSrc  = 2'b01;
                reg_we     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adrSrc     = 1'b1;
                mem_we     = 1'b1;
                state_next = S_FETCH;
            end
            S_EXECR: begin
                aluSrcA    = 2'b10;
                aluOp      = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                aluSrcA    = 2'b10;
                aluSrcB    = 2'b01;
                aluOp      = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                aluSrcA    = 2'b10;
                aluOp      = 2'b01;
                pc_we      = branch_taken;
                state_next = S_FETCH;
            end
            S_JAL: begin
                // PC <= target held in aluOut; ALU forms oldPC+4 for the link.
                aluSrcA    = 2'b01;
                aluSrcB    = 2'b10;
                pc_we      = 1'b1;
                state_next = S_ALUWB;
            end
            S_JALR: begin
                aluSrcA    = 2'b10;
                aluSrcB    = 2'b01;
                state_next = S_JALRPC;
            end
            S_JALRPC: begin
                aluSrcA    = 2'b01;
                aluSrcB    = 2'b10;
                pc_we      = 1'b1;
                state_next = S_ALUWB;
            end
            S_LUI: begin
                immSrc     = 3'b100;
                resultSrc  = 2'b11;
                reg_we     = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_HALT;
            end
        endcase
    end

    // Architectural writes are suppressed while reset is held so an aborted
    // instruction leaves no trace.
    assign pcWrite    = pc_we  & ~rst;
    assign memWrite   = mem_we & ~rst;
    assign irWrite    = ir_we  & ~rst;
    assign regWrite   = reg_we & ~rst;
    assign halted     = halted_q;
    assign instrCount = count_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb/tb_multi_cycle_controller.sv - scoreboard bench for multi_cycle_controller

module tb_multi_cycle_controller;

    logic        clk;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        zero;
    logic        lt;

    logic        pcWrite, adrSrc, memWrite, irWrite, regWrite, halted;
    logic [1:0]  resultSrc, aluSrcA, aluSrcB, aluOp;
    logic [2:0]  immSrc;
    logic [31:0] instrCount;

    logic        pcWrite4, adrSrc4, memWrite4, irWrite4, regWrite4, halted4;
    logic [1:0]  resultSrc4, aluSrcA4, aluSrcB4, aluOp4;
    logic [2:0]  immSrc4;
    logic [3:0]  instrCount4;

    int tests_run;
    int tests_failed;
    int model_cnt;
    logic [16:0] exp_q[$];

    multi_cycle_controller #(.CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero), .lt(lt),
        .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite), .irWrite(irWrite),
        .regWrite(regWrite), .resultSrc(resultSrc), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .aluOp(aluOp), .immSrc(immSrc), .halted(halted),
        .instrCount(instrCount)
    );

    multi_cycle_controller #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero), .lt(lt),
        .pcWrite(pcWrite4), .adrSrc(adrSrc4), .memWrite(memWrite4), .irWrite(irWrite4),
        .regWrite(regWrite4), .resultSrc(resultSrc4), .aluSrcA(aluSrcA4),
        .aluSrcB(aluSrcB4), .aluOp(aluOp4), .immSrc(immSrc4), .halted(halted4),
        .instrCount(instrCount4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] cv(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] aop, input logic [2:0] imm,
                                       input logic h);
        return {h, pcw, adr, mw, irw, rw, rs, a, b, aop, imm};
    endfunction

    function automatic logic [16:0] observed();
        return {halted, pcWrite, adrSrc, memWrite, irWrite, regWrite,
                resultSrc, aluSrcA, aluSrcB, aluOp, immSrc};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; compares one queued control vector per cycle.
    task automatic play(input string tag);
        logic [16:0] e;
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            check(tag, {15'b0, observed()}, {15'b0, e});
            @(negedge clk);
        end
    endtask

    task automatic check_count(input string tag);
        #1;
        check({tag, "_cnt"}, instrCount, model_cnt);
        check({tag, "_cnt4"}, {28'b0, instrCount4}, {28'b0, 4'(model_cnt)});
    endtask

    task automatic instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                         input logic z, input logic l, input logic tk);
        op = o; funct3 = f3; zero = z; lt = l;
        exp_q.push_back(cv(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        case (o)
            7'b0110011: begin
                exp_q.push_back(cv(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
                exp_q.push_back(cv(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b000,0));
                exp_q.push_back(cv(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
            end
            7'b0010011: begin
                exp_q.push_back(cv(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
                exp_q.push_back(cv(0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,3'b000,0));
                exp_q.push_back(cv(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
            end
            7'b0000011: begin
                exp_q.push_back(cv(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
                exp_q.push_back(cv(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
                exp_q.push_back(cv(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
                exp_q.push_back(cv(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0));
            end
            7'b0100011: begin
                exp_q.push_back(cv(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
                exp_q.push_back(cv(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b001,0));
                exp_q.push_back(cv(0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
            end
            7'b1100011: begin
                exp_q.push_back(cv(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b011,0));
                exp_q.push_back(cv(tk,0,0,0,0,2'b00,2'b10,2'b00,2'b01,3'b000,0));
            end
            7'b1101111: begin
                exp_q.push_back(cv(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b010,0));
                exp_q.push_back(cv(1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,3'b000,0));
                exp_q.push_back(cv(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
            end
            7'b1100111: begin
                exp_q.push_back(cv(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
                exp_q.push_back(cv(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
                exp_q.push_back(cv(1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,3'b000,0));
                exp_q.push_back(cv(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
            end
            7'b0110111: begin
                exp_q.push_back(cv(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
                exp_q.push_back(cv(0,0,0,0,1,2'b11,2'b00,2'b00,2'b00,3'b100,0));
            end
            default: begin
                exp_q.push_back(cv(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
            end
        endcase
        play(tag);
        model_cnt++;
        check_count(tag);
    endtask

    initial begin
        tests_run = 0; tests_failed = 0; model_cnt = 0;
        rst = 1'b1; op = 7'b0; funct3 = 3'b0; zero = 1'b0; lt = 1'b0;

        // Reset: FETCH decoded, write enables held off, counters clear.
        @(negedge clk); @(negedge clk);
        #1;
        check("rst_ctl", {15'b0, observed()},
              {15'b0, cv(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0)});
        check("rst_cnt", instrCount, 32'd0);
        rst = 1'b0;

        instr("add",  7'b0110011, 3'b000, 0, 0, 0);
        instr("lw",   7'b0000011, 3'b010, 0, 0, 0);
        instr("sw",   7'b0100011, 3'b010, 0, 0, 0);
        instr("beq1", 7'b1100011, 3'b000, 1, 0, 1);
        instr("beq0", 7'b1100011, 3'b000, 0, 0, 0);
        instr("blt1", 7'b1100011, 3'b100, 0, 1, 1);
        instr("f010", 7'b1100011, 3'b010, 1, 1, 0);
        instr("bne",  7'b1100011, 3'b001, 0, 0, 1);
        instr("bge",  7'b1100011, 3'b101, 0, 1, 0);
        instr("jal",  7'b1101111, 3'b000, 0, 0, 0);
        instr("jalr", 7'b1100111, 3'b000, 0, 0, 0);
        instr("lui",  7'b0110111, 3'b000, 0, 0, 0);

        // Reset asserted during MEMREAD of a load: no write-back, count cleared.
        op = 7'b0000011; funct3 = 3'b010;
        exp_q.push_back(cv(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        exp_q.push_back(cv(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        exp_q.push_back(cv(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
        play("lw_abort");
        rst = 1'b1;
        #1;
        check("abort_memread", {15'b0, observed()},
              {15'b0, cv(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0)});
        @(negedge clk);
        #1;
        check("abort_fetch", {15'b0, observed()},
              {15'b0, cv(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0)});
        model_cnt = 0;
        check_count("abort");
        rst = 1'b0;

        // 16 addi: the 4-bit counter must wrap back to 0.
        for (int i = 0; i < 16; i++) begin
            instr("addi", 7'b0010011, 3'b000, 0, 0, 0);
        end
        check("wrap4", {28'b0, instrCount4}, 32'd0);

        // Illegal opcode: HALT for 10 cycles, then reset recovers.
        op = 7'b1111111;
        exp_q.push_back(cv(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        exp_q.push_back(cv(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(cv(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1));
        end
        play("halt");
        check_count("halt");
        rst = 1'b1;
        #1;
        check("halt_rst", {15'b0, observed()},
              {15'b0, cv(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1)});
        @(negedge clk);
        #1;
        check("halt_clear", {15'b0, observed()},
              {15'b0, cv(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0)});
        model_cnt = 0;
        rst = 1'b0;
        instr("add2", 7'b0110011, 3'b000, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
